// File: rtl/axis_string_arbiter.sv
// Round-robin, message-locked arbiter feeding one byte-wide AXIS stream; tuser carries the source index.
// Define ARB_TIMEOUT_EN to close a stalled message by injecting TERMINATION after TIMEOUT_CYCLES idle cycles.
module axis_string_arbiter #(
  parameter int          SLAVES         = 2,
  parameter int          ID_WIDTH       = 1,
  parameter logic [7:0]  TERMINATION    = 8'h0A,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [SLAVES*8-1:0]   s_axis_tdata,
  input  logic [SLAVES-1:0]     s_axis_tvalid,
  output logic [SLAVES-1:0]     s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [SLAVES-1:0]     grant
);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PASS = 2'd1, S_FLUSH = 2'd2} state_t;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PASS = 2'd1} state_t;
`endif

  state_t               r_state, w_state_nxt;
  logic [SLAVES-1:0]    r_grant, w_grant_nxt, w_sel_onehot;
  logic [ID_WIDTH-1:0]  r_grant_idx, w_grant_idx_nxt, r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_WIDTH-1:0]  w_sel_idx, w_hi_idx, w_lo_idx, w_idx_inc;
  logic                 w_found, w_hi_found, w_out_free, w_src_valid, w_src_hs;
  logic [7:0]           w_src_byte;
  logic [7:0]           r_m_tdata, w_m_tdata_nxt;
  logic [ID_WIDTH-1:0]  r_m_tuser, w_m_tuser_nxt;
  logic                 r_m_tvalid, w_m_tvalid_nxt, r_m_tlast, w_m_tlast_nxt;

  assign w_out_free = !r_m_tvalid || m_axis_tready;
  assign w_src_hs   = (r_state == S_PASS) && w_src_valid && w_out_free;
  assign w_idx_inc  = (r_grant_idx == ID_WIDTH'(SLAVES - 1)) ? '0 : r_grant_idx + 1'b1;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    w_found    = 1'b0;
    w_hi_found = 1'b0;
    w_lo_idx   = '0;
    w_hi_idx   = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        w_found  = 1'b1;
        w_lo_idx = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_WIDTH'(i);
        end
      end
    end
    w_sel_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
    w_sel_onehot = '0;
    w_src_byte   = '0;
    w_src_valid  = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      w_sel_onehot[i] = (ID_WIDTH'(i) == w_sel_idx);
      if (ID_WIDTH'(i) == r_grant_idx) begin
        w_src_byte  = s_axis_tdata[i*8 +: 8];
        w_src_valid = s_axis_tvalid[i];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_m_tdata_nxt   = r_m_tdata;
    w_m_tuser_nxt   = r_m_tuser;
    w_m_tlast_nxt   = r_m_tlast;
    w_m_tvalid_nxt  = r_m_tvalid && !m_axis_tready;
    s_axis_tready   = '0;
`ifdef ARB_TIMEOUT_EN
    w_to_cnt_nxt    = r_to_cnt;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef ARB_TIMEOUT_EN
        w_to_cnt_nxt = '0;
`endif
        if (w_found) begin
          w_state_nxt     = S_PASS;
          w_grant_nxt     = w_sel_onehot;
          w_grant_idx_nxt = w_sel_idx;
        end
      end
      S_PASS: begin
        for (int i = 0; i < SLAVES; i++)
          if (ID_WIDTH'(i) == r_grant_idx) s_axis_tready[i] = w_out_free;
        if (w_src_hs) begin
          w_m_tdata_nxt  = w_src_byte;
          w_m_tuser_nxt  = r_grant_idx;
          w_m_tlast_nxt  = (w_src_byte == TERMINATION);
          w_m_tvalid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_to_cnt_nxt   = '0;
`endif
          if (w_src_byte == TERMINATION) begin
            w_state_nxt  = S_IDLE;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = w_idx_inc;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (!w_src_valid) begin
          if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt  = S_FLUSH;
            w_to_cnt_nxt = '0;
          end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
          end
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      S_FLUSH: begin
        if (w_out_free) begin
          w_m_tdata_nxt  = TERMINATION;
          w_m_tuser_nxt  = r_grant_idx;
          w_m_tlast_nxt  = 1'b1;
          w_m_tvalid_nxt = 1'b1;
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_rr_ptr_nxt   = w_idx_inc;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_m_tdata   <= '0;
      r_m_tuser   <= '0;
      r_m_tlast   <= 1'b0;
      r_m_tvalid  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_m_tdata   <= w_m_tdata_nxt;
      r_m_tuser   <= w_m_tuser_nxt;
      r_m_tlast   <= w_m_tlast_nxt;
      r_m_tvalid  <= w_m_tvalid_nxt;
`ifdef ARB_TIMEOUT_EN
      r_to_cnt    <= w_to_cnt_nxt;
`endif
    end
  end

  assign grant         = r_grant;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;

endmodule
